// File: rtl/regfile_sb_if.sv
// Bundle of read, issue, writeback and clear signals between the pipeline and regfile_sb.
// The master side is decode/issue/writeback; the slave side is the register file.
interface regfile_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr_i;
    logic [XLEN-1:0] rs1_data_o;
    logic            rs1_busy_o;
    logic [AW-1:0]   rs2_addr_i;
    logic [XLEN-1:0] rs2_data_o;
    logic            rs2_busy_o;
    logic            issue_valid_i;
    logic [AW-1:0]   issue_rd_i;
    logic            issue_ready_o;
    logic            wr_en;
    logic [AW-1:0]   wr_addr_i;
    logic [XLEN-1:0] wr_data_i;
    logic            clear_req_i;
    logic            clear_busy_o;
    logic            clear_done_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
               wr_en, wr_addr_i, wr_data_i, clear_req_i,
        input  rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o,
               issue_ready_o, clear_busy_o, clear_done_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
               wr_en, wr_addr_i, wr_data_i, clear_req_i,
        output rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o,
               issue_ready_o, clear_busy_o, clear_done_o
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with optional write-to-read bypass, per-register
// busy scoreboard for in-order issue, and a sequential clear engine for soft flush.
module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    regfile_sb_if.slave     bus,
    output logic [XLEN-1:0] regA0
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    logic            idle;
    logic            wr_acc;
    logic            iss_acc;
    logic            start_clear;

    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];

    assign idle        = (state_q == IDLE);
    assign wr_acc      = bus.wr_en && idle && (bus.wr_addr_i != '0);
    assign start_clear = idle && bus.clear_req_i;

    // A pending write to the claimed rd retires this cycle, so the new producer may take it.
    assign bus.issue_ready_o = idle &&
        (!busy[bus.issue_rd_i] || (wr_acc && (bus.wr_addr_i == bus.issue_rd_i)));
    assign iss_acc = bus.issue_valid_i && bus.issue_ready_o && (bus.issue_rd_i != '0);

    assign bus.clear_busy_o = (state_q == CLEAR) || (state_q == DONE);
    assign bus.clear_done_o = (state_q == DONE);

    // ------------------------------------------------------------------ read ports
    assign rd_addr[0] = bus.rs1_addr_i;
    assign rd_addr[1] = bus.rs2_addr_i;

    for (genvar p = 0; p < 2; p++) begin : g_read
        logic fwd;
        assign fwd = BYPASS && wr_acc && (bus.wr_addr_i == rd_addr[p]);

        // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if (fwd) begin
                rd_data[p] = bus.wr_data_i;
                rd_busy[p] = 1'b0;
            end
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.rs1_data_o = rd_data[0];
    assign bus.rs1_busy_o = rd_busy[0];
    assign bus.rs2_data_o = rd_data[1];
    assign bus.rs2_busy_o = rd_busy[1];

    if (NREGS > 10) begin : g_a0
        assign regA0 = regs[10];
    end else begin : g_no_a0
        assign regA0 = '0;
    end

    // ------------------------------------------------------------------ clear FSM
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.clear_req_i) state_d = CLEAR;
            CLEAR:   if (cnt_q == AW'(NREGS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter starts at 1: x0 is hardwired zero and never needs clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt_q <= '0;
        else if (start_clear)       cnt_q <= AW'(1);
        else if (state_q == CLEAR)  cnt_q <= cnt_q + AW'(1);
    end

    // ------------------------------------------------------------------ storage
    // NOTE: the register array is reset explicitly because the architecture requires all-zero contents out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (wr_acc)            regs[bus.wr_addr_i] <= bus.wr_data_i;
            if (state_q == CLEAR)  regs[cnt_q] <= '0;
        end
    end

    // Issue after write on the same rd leaves busy set: the new producer owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (start_clear) begin
            busy <= '0;
        end else begin
            if (wr_acc)  busy[bus.wr_addr_i] <= 1'b0;
            if (iss_acc) busy[bus.issue_rd_i] <= 1'b1;
        end
    end
endmodule
